// File: rtl/ravenoc_pkg.sv
// Shared NoC types: flit request/response structs, flit-type enum, coordinate/length widths and HEAD layout.
package ravenoc_pkg;

  localparam int FLIT_WIDTH  = 34;
  localparam int FLIT_DATA_W = 32;
  localparam int XWIDTH      = 4;
  localparam int YWIDTH      = 4;
  localparam int PKT_WIDTH   = 10;
  localparam int HEAD_RSVD_W = FLIT_DATA_W - XWIDTH - YWIDTH - PKT_WIDTH;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } tx_state_t;

  // HEAD payload, MSB-first: destination X, destination Y, payload length, zero pad
  typedef struct packed {
    logic [XWIDTH-1:0]      x_dest;
    logic [YWIDTH-1:0]      y_dest;
    logic [PKT_WIDTH-1:0]   pkt_len;
    logic [HEAD_RSVD_W-1:0] rsvd;
  } s_head_t;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] fdata;
    logic                  valid;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;

  function automatic logic [FLIT_WIDTH-1:0] mk_flit(input flit_type_t t,
                                                    input logic [FLIT_DATA_W-1:0] d);
    return {t, d};
  endfunction

  function automatic logic [FLIT_DATA_W-1:0] mk_head(input logic [XWIDTH-1:0] x,
                                                     input logic [YWIDTH-1:0] y,
                                                     input logic [PKT_WIDTH-1:0] len);
    s_head_t h;
    h = '{x_dest: x, y_dest: y, pkt_len: len, rsvd: '0};
    return h;
  endfunction

endpackage

// File: rtl/ni_pkt_tx_if.sv
// Command, payload and router-facing flit signals of the packet transmitter.
interface ni_pkt_tx_if;
  import ravenoc_pkg::*;

  logic                   pkt_valid_i;
  logic                   pkt_ready_o;
  logic [XWIDTH-1:0]      pkt_x_dest_i;
  logic [YWIDTH-1:0]      pkt_y_dest_i;
  logic [PKT_WIDTH-1:0]   pkt_len_i;
  logic                   pld_valid_i;
  logic                   pld_ready_o;
  logic [FLIT_DATA_W-1:0] pld_data_i;
  s_flit_req_t            flit_req_o;
  s_flit_resp_t           flit_resp_i;
  logic                   err_o;
  logic                   busy_o;

  modport master (
    output pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_len_i,
    output pld_valid_i, pld_data_i, flit_resp_i,
    input  pkt_ready_o, pld_ready_o, flit_req_o, err_o, busy_o
  );

  modport slave (
    input  pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_len_i,
    input  pld_valid_i, pld_data_i, flit_resp_i,
    output pkt_ready_o, pld_ready_o, flit_req_o, err_o, busy_o
  );

endinterface

// File: rtl/ni_pkt_tx.sv
// Packet transmitter: command + payload words -> HEAD/BODY/TAIL flits, flit valid one cycle after accept.
// The flit register holds until router ready; both command and payload handshakes stall behind it.
module ni_pkt_tx
  import ravenoc_pkg::*;
#(
  parameter int ROUTER_X_ID = 0,
  parameter int ROUTER_Y_ID = 0,
  parameter int MAX_SZ_PKT  = 256
) (
  input  logic       clk,
  input  logic       arst,
  ni_pkt_tx_if.slave nif
);

  localparam int          CNT_W   = $clog2(MAX_SZ_PKT + 1);
  localparam int unsigned MAX_LEN = MAX_SZ_PKT;

  tx_state_t        state_q, state_d;
  s_flit_req_t      flit_q, flit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic pkt_rdy, pld_rdy, busy;
  logic out_free, cmd_acc, pld_acc;
  logic is_local, too_long, has_pld, last_word;

  assign out_free  = !flit_q.valid || nif.flit_resp_i.ready;
  assign cmd_acc   = nif.pkt_valid_i && pkt_rdy;
  assign pld_acc   = nif.pld_valid_i && pld_rdy;
  assign is_local  = (nif.pkt_x_dest_i == XWIDTH'(ROUTER_X_ID)) &&
                     (nif.pkt_y_dest_i == YWIDTH'(ROUTER_Y_ID));
  assign too_long  = 32'(nif.pkt_len_i) > MAX_LEN;
  assign has_pld   = nif.pkt_len_i != '0;
  assign last_word = cnt_q == CNT_W'(1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Oversized commands are swallowed outright, so length is checked before locality
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_acc && !too_long && has_pld) state_d = is_local ? ST_DROP : ST_BODY;
      ST_BODY,
      ST_DROP: if (pld_acc && last_word) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_rdy = 1'b0;
    pld_rdy = 1'b0;
    case (state_q)
      ST_IDLE: pkt_rdy = out_free && !arst;
      ST_BODY: pld_rdy = out_free;
      ST_DROP: pld_rdy = 1'b1;
      default: ;
    endcase
    busy = (state_q != ST_IDLE) || flit_q.valid;
  end

  always_comb begin
    flit_d = flit_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (out_free) flit_d.valid = 1'b0;
    if (cmd_acc) begin
      err_d = is_local || too_long;
      if (!too_long) cnt_d = nif.pkt_len_i[CNT_W-1:0];
      if (!is_local && !too_long) begin
        flit_d.fdata = mk_flit(HEAD_FLIT, mk_head(nif.pkt_x_dest_i, nif.pkt_y_dest_i, nif.pkt_len_i));
        flit_d.valid = 1'b1;
      end
    end
    if (pld_acc) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (state_q == ST_BODY) begin
        flit_d.fdata = mk_flit(last_word ? TAIL_FLIT : BODY_FLIT, nif.pld_data_i);
        flit_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      flit_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      flit_q <= flit_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign nif.pkt_ready_o = pkt_rdy;
  assign nif.pld_ready_o = pld_rdy;
  assign nif.flit_req_o  = flit_q;
  assign nif.err_o       = err_q;
  assign nif.busy_o      = busy;

endmodule

// File: tb/tb_ni_pkt_tx.sv
// Bench for ni_pkt_tx at router (0,0): vector table, hand-written corner sequences, randomized traffic vs a packet-level model.
module tb_ni_pkt_tx;
  import ravenoc_pkg::*;

  localparam int MAX = 256;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  ni_pkt_tx_if nif();

  ni_pkt_tx #(.ROUTER_X_ID(0), .ROUTER_Y_ID(0), .MAX_SZ_PKT(MAX)) dut (
    .clk (clk),
    .arst(arst),
    .nif (nif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // monitor-owned observations
  logic [33:0] got_q[$];
  int err_cnt = 0, cons_cnt = 0, hold_viol = 0, hold_seen = 0;
  logic hold_pend = 1'b0;
  logic [33:0] hold_dat = '0;

  // main-owned expectations and baselines
  logic [33:0] exp_q[$];
  int exp_err = 0, exp_cons = 0;
  int got_base = 0, err_base = 0, cons_base = 0, viol_base = 0, seen_base = 0;

  int rdy_mode = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    int          len;
    int          err;
    int          nfl;
    int          cons;
    logic [33:0] head;
  } vec_t;
  vec_t vt[7];

  always @(negedge clk) begin
    if (arst) begin
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        hold_seen <= hold_seen + 1;
        if (!nif.flit_req_o.valid || nif.flit_req_o.fdata != hold_dat) hold_viol <= hold_viol + 1;
      end
      if (nif.flit_req_o.valid && !nif.flit_resp_i.ready && nif.pld_ready_o) hold_viol <= hold_viol + 1;
      hold_pend <= nif.flit_req_o.valid && !nif.flit_resp_i.ready;
      hold_dat  <= nif.flit_req_o.fdata;
      if (nif.flit_req_o.valid && nif.flit_resp_i.ready) got_q.push_back(nif.flit_req_o.fdata);
      if (nif.err_o) err_cnt <= err_cnt + 1;
      if (nif.pld_valid_i && nif.pld_ready_o) cons_cnt <= cons_cnt + 1;
    end
  end

  // Router ready: always high, random, or a two-cycle stall on BODY A1
  initial begin
    nif.flit_resp_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        nif.flit_resp_i.ready = 1'b1;
        stall_cnt = 0;
      end else if (rdy_mode == 1) begin
        nif.flit_resp_i.ready = ($urandom_range(0, 3) != 0);
        stall_cnt = 0;
      end else if (nif.flit_req_o.valid && nif.flit_req_o.fdata == {2'd1, 32'h0000_00A1} && stall_cnt < 2) begin
        nif.flit_resp_i.ready = 1'b0;
        stall_cnt++;
      end else begin
        nif.flit_resp_i.ready = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic do_cmd(input logic [3:0] x, input logic [3:0] y, input int len, output int waits);
    nif.pkt_x_dest_i = x;
    nif.pkt_y_dest_i = y;
    nif.pkt_len_i    = PKT_WIDTH'(len);
    nif.pkt_valid_i  = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (nif.pkt_ready_o) break;
      waits++;
      if (waits > 500) begin fail_bound("cmd_accept"); break; end
    end
    @(posedge clk); #1;
    nif.pkt_valid_i = 1'b0;
  endtask

  task automatic do_word(input logic [31:0] d, output int waits);
    nif.pld_data_i  = d;
    nif.pld_valid_i = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (nif.pld_ready_o) break;
      waits++;
      if (waits > 500) begin fail_bound("pld_accept"); break; end
    end
    @(posedge clk); #1;
    nif.pld_valid_i = 1'b0;
  endtask

  // Packet-level reference: what leaves the block for one command
  task automatic model(input logic [3:0] x, input logic [3:0] y, input int len,
                       input logic [31:0] d[$], output int nw);
    if (len > MAX) begin
      exp_err++;
      nw = 0;
    end else if (x == 4'd0 && y == 4'd0) begin
      exp_err++;
      exp_cons += len;
      nw = len;
    end else begin
      exp_q.push_back({2'd0, x, y, 10'(len), 14'd0});
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) ? 2'd2 : 2'd1, d[i]});
      exp_cons += len;
      nw = len;
    end
  endtask

  task automatic run_pkt(input logic [3:0] x, input logic [3:0] y, input int len,
                         input bit gaps, input bit fixed, output int maxw);
    logic [31:0] d[$];
    int nw, w;
    for (int i = 0; i < len; i++) d.push_back(fixed ? 32'hA0 + 32'(i) : $urandom);
    model(x, y, len, d, nw);
    do_cmd(x, y, len, w);
    maxw = w;
    for (int i = 0; i < nw; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      do_word(d[i], w);
      if (w > maxw) maxw = w;
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (nif.busy_o && n < 2000);
    if (nif.busy_o) fail_bound("drain");
    @(posedge clk); #1;
  endtask

  task automatic mark();
    got_base  = got_q.size();
    err_base  = err_cnt;
    cons_base = cons_cnt;
    viol_base = hold_viol;
    seen_base = hold_seen;
    exp_q.delete();
    exp_err  = 0;
    exp_cons = 0;
  endtask

  task automatic compare(input string name);
    check({name, "_nflits"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++)
      check($sformatf("%s_flit%0d", name, i), got_q[got_base + i], exp_q[i]);
    check({name, "_err"}, err_cnt - err_base, exp_err);
    check({name, "_cons"}, cons_cnt - cons_base, exp_cons);
    check({name, "_hold"}, hold_viol - viol_base, 0);
  endtask

  initial begin
    int w, w2;
    logic [3:0] rx, ry;
    int rl, r;

    vt[0] = '{4'd1,  4'd0,  0,   0, 1,   0,   34'h0_1000_0000};
    vt[1] = '{4'd0,  4'd1,  3,   0, 4,   3,   34'h0_0100_C000};
    vt[2] = '{4'd0,  4'd0,  2,   1, 0,   2,   34'h0};
    vt[3] = '{4'd2,  4'd3,  257, 1, 0,   0,   34'h0};
    vt[4] = '{4'd0,  4'd0,  0,   1, 0,   0,   34'h0};
    vt[5] = '{4'd15, 4'd15, 256, 0, 257, 256, 34'h0_FF40_0000};
    vt[6] = '{4'd3,  4'd5,  1,   0, 2,   1,   34'h0_3500_4000};

    nif.pkt_valid_i  = 1'b1;
    nif.pkt_x_dest_i = 4'd1;
    nif.pkt_y_dest_i = 4'd1;
    nif.pkt_len_i    = '0;
    nif.pld_valid_i  = 1'b1;
    nif.pld_data_i   = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flit", nif.flit_req_o, 0);
    check("rst_err", nif.err_o, 0);
    check("rst_pkt_rdy", nif.pkt_ready_o, 0);
    check("rst_pld_rdy", nif.pld_ready_o, 0);
    check("rst_busy", nif.busy_o, 0);
    @(posedge clk); #1;
    nif.pkt_valid_i = 1'b0;
    nif.pld_valid_i = 1'b0;
    arst = 1'b0;
    @(posedge clk); #1;

    // HEAD timing: valid exactly one cycle after accept, no payload requested
    mark();
    nif.pkt_x_dest_i = 4'd1;
    nif.pkt_y_dest_i = 4'd0;
    nif.pkt_len_i    = '0;
    nif.pkt_valid_i  = 1'b1;
    @(negedge clk);
    check("head_acc_rdy", nif.pkt_ready_o, 1);
    check("head_acc_novld", nif.flit_req_o.valid, 0);
    @(posedge clk); #1;
    nif.pkt_valid_i = 1'b0;
    @(negedge clk);
    check("head_vld", nif.flit_req_o.valid, 1);
    check("head_dat", nif.flit_req_o.fdata, 34'h0_1000_0000);
    check("head_pld_rdy", nif.pld_ready_o, 0);
    check("head_busy", nif.busy_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("head_drained", nif.flit_req_o.valid, 0);
    drain();

    for (int i = 0; i < 7; i++) begin
      mark();
      run_pkt(vt[i].x, vt[i].y, vt[i].len, 1'b0, 1'b0, w);
      drain();
      check($sformatf("vec%0d_err", i), err_cnt - err_base, vt[i].err);
      check($sformatf("vec%0d_nfl", i), got_q.size() - got_base, vt[i].nfl);
      check($sformatf("vec%0d_cons", i), cons_cnt - cons_base, vt[i].cons);
      if (vt[i].nfl > 0) begin
        if (got_q.size() > got_base) check($sformatf("vec%0d_head", i), got_q[got_base], vt[i].head);
        else check($sformatf("vec%0d_head_missing", i), 0, 1);
      end
      compare($sformatf("vec%0d", i));
    end

    // Back-to-back: no payload bubbles, next command taken while TAIL drains
    mark();
    run_pkt(4'd2, 4'd1, 2, 1'b0, 1'b0, w);
    run_pkt(4'd1, 4'd2, 1, 1'b0, 1'b0, w2);
    drain();
    check("b2b_first_waits", w, 0);
    check("b2b_second_waits", w2, 0);
    compare("b2b");

    // Router stall on BODY A1 for two cycles
    rdy_mode = 2;
    mark();
    run_pkt(4'd0, 4'd1, 3, 1'b0, 1'b1, w);
    drain();
    check("stall_cycles", stall_cnt, 2);
    check("stall_held", hold_seen - seen_base, 2);
    compare("stall");
    rdy_mode = 0;
    @(posedge clk); #1;

    // Oversized command: error, no payload, immediately ready again
    mark();
    nif.pld_valid_i = 1'b1;
    nif.pld_data_i  = 32'hDEAD_BEEF;
    do_cmd(4'd1, 4'd1, MAX + 1, w);
    @(negedge clk);
    check("big_err", nif.err_o, 1);
    check("big_pkt_rdy", nif.pkt_ready_o, 1);
    check("big_pld_rdy", nif.pld_ready_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("big_err_pulse", nif.err_o, 0);
    check("big_pld_rdy2", nif.pld_ready_o, 0);
    @(posedge clk); #1;
    nif.pld_valid_i = 1'b0;
    check("big_cons", cons_cnt - cons_base, 0);
    check("big_nfl", got_q.size() - got_base, 0);

    // Reset in the middle of a len=4 packet, then a fresh len=1 packet
    do_cmd(4'd0, 4'd1, 4, w);
    do_word(32'hB0, w);
    check("prerst_body", nif.flit_req_o.fdata, {2'd1, 32'hB0});
    arst = 1'b1;
    #1;
    check("midrst_flit", nif.flit_req_o, 0);
    check("midrst_busy", nif.busy_o, 0);
    check("midrst_pkt_rdy", nif.pkt_ready_o, 0);
    check("midrst_pld_rdy", nif.pld_ready_o, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;
    mark();
    run_pkt(4'd0, 4'd1, 1, 1'b0, 1'b0, w);
    drain();
    check("postrst_nfl", got_q.size() - got_base, 2);
    compare("postrst");

    // Randomized traffic with random router backpressure and payload gaps
    rdy_mode = 1;
    mark();
    for (int i = 0; i < 40; i++) begin
      rx = 4'($urandom_range(0, 3));
      ry = 4'($urandom_range(0, 3));
      if (i % 13 == 5) begin rx = 4'd0; ry = 4'd0; end
      r  = $urandom_range(0, 19);
      rl = (r == 0) ? $urandom_range(MAX + 1, MAX + 40) : (r == 1) ? 0 : $urandom_range(0, 10);
      run_pkt(rx, ry, rl, 1'b1, 1'b0, w);
    end
    drain();
    compare("rand");
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_pkt_tx.md
NI_PKT_TX -- requirements
Module: ni_pkt_tx

Interface
REQ-001 Parameter ROUTER_X_ID, default 0, X coordinate of the attached router.
REQ-002 Parameter ROUTER_Y_ID, default 0, Y coordinate of the attached router.
REQ-003 Parameter MAX_SZ_PKT, default 256, maximum payload flits per packet.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 arst  input  1  asynchronous active-high reset.
REQ-006 pkt_valid_i / pkt_ready_o  in/out  1/1  packet-command handshake.
REQ-007 pkt_x_dest_i, pkt_y_dest_i  input  XWIDTH/YWIDTH  destination router coordinates.
REQ-008 pkt_len_i  input  PKT_WIDTH  payload flit count; 0 means head-only packet.
REQ-009 pld_valid_i / pld_ready_o / pld_data_i  in/out/in  1/1/32  payload word stream.
REQ-010 flit_req_o  output  s_flit_req_t  flit toward the router local receive port (fdata, valid).
REQ-011 flit_resp_i  input  s_flit_resp_t  router ready.
REQ-012 err_o  output  1  one-cycle pulse on an illegal command.
REQ-013 busy_o  output  1  high whenever state is not IDLE or flit_req_o.valid is high.

Function
REQ-014 Flit format: fdata[33:32] carries the type (HEAD=0, BODY=1, TAIL=2); fdata[31:0] carries the payload for BODY and TAIL flits.
REQ-015 HEAD fdata[31:0] packs x_dest, y_dest and pkt_len, MSB-first, with the remaining LSBs zero.
REQ-016 FSM states are IDLE, BODY and DROP.
REQ-017 In IDLE, pkt_ready_o = !flit_req_o.valid || flit_resp_i.ready; it is 0 in every other state.
REQ-018 On command accept of a legal packet, the HEAD flit is loaded into the output register, so valid appears one cycle after accept.
REQ-019 After a legal accept, the next state is BODY if pkt_len_i >= 1, otherwise IDLE.
REQ-020 flit_req_o SHALL hold valid and fdata stable until the cycle in which flit_resp_i.ready is 1.
REQ-021 In BODY, pld_ready_o = !flit_req_o.valid || flit_resp_i.ready; each accepted word loads one flit, giving one flit per cycle with no bubbles.
REQ-022 A remaining-count register, width $clog2(MAX_SZ_PKT+1), is loaded with pkt_len_i and decremented per accepted word.
REQ-023 The flit loaded when the remaining count equals 1 is typed TAIL, and the FSM returns to IDLE; all earlier payload flits are typed BODY.
REQ-024 A new command may be accepted in the same cycle that the previous TAIL is drained (back-to-back packets).
REQ-025 Destination equal to (ROUTER_X_ID, ROUTER_Y_ID): the command is accepted, err_o pulses, no flits are emitted, the FSM enters DROP when len >= 1 and otherwise stays in IDLE.
REQ-026 In DROP, pld_ready_o = 1 and pkt_len_i words are consumed and discarded; the FSM returns to IDLE after the last word.
REQ-027 pkt_len_i > MAX_SZ_PKT: the command is accepted, err_o pulses, no flits are emitted, no payload is consumed, and the FSM stays in IDLE.
REQ-028 pld_ready_o SHALL be 0 in IDLE.

Reset
REQ-029 While arst is high: state=IDLE, flit_req_o='0, remaining count=0, err_o=0, pkt_ready_o=0, pld_ready_o=0, busy_o=0.
REQ-030 Reset mid-packet SHALL abandon the packet immediately, with no TAIL emitted; the first command after reset release starts a fresh HEAD.

Structure
REQ-031 The following belong in ravenoc_pkg: s_flit_req_t, s_flit_resp_t, the flit-type enum, FLIT_WIDTH=34, XWIDTH, YWIDTH, PKT_WIDTH and the HEAD field layout.
REQ-032 The block is a single module, with no sub-modules.

Verification
REQ-033 At router (0,0): command dest(1,0), len=0 -> one HEAD flit with type 0, x=1, y=0, len=0 one cycle after accept; no pld_ready_o.
REQ-034 Command dest(0,1), len=3, payload A0,A1,A2, router ready always high -> HEAD, BODY A0, BODY A1, TAIL A2 on four consecutive cycles.
REQ-035 Same as REQ-034 with ready low for 2 cycles on BODY A1 -> A1 is held stable and pld_ready_o=0 until ready, with no loss or duplication.
REQ-036 Command dest(0,0), len=2 -> err_o pulses once, two payload words are consumed, and zero flits are emitted.
REQ-037 Command len=MAX_SZ_PKT+1 -> err_o pulses, pld_ready_o stays 0, and pkt_ready_o returns high the next cycle.
REQ-038 arst asserted after BODY 1 of a len=4 packet -> outputs are zero immediately; the next len=1 command emits HEAD then TAIL.
